// File: rtl/ir_line_seq.sv
// Sweeps the six IR line sensors through the shared A2D and folds the readings
// into one signed, saturated steering error per sweep.
module ir_line_seq #(
  parameter int unsigned SETTLE_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        cnv_cmplt,
  input  logic [11:0] A2D_res,
  output logic        strt_cnv,
  output logic [2:0]  chnl,
  output logic        IR_en,
  output logic        busy,
  output logic [15:0] error,
  output logic        err_vld
);

  localparam int unsigned CW = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, START, WAIT} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [2:0]          r_idx;
  logic [2:0]          r_chnl;
  logic signed [16:0]  r_acc;
  logic [15:0]         r_error;
  logic                r_err_vld;
  logic                r_ir_en;

  logic                w_settle_done;
  logic                w_last;
  logic                w_strt;
  logic [2:0]          w_idx_nxt;
  logic signed [16:0]  w_mag;
  logic signed [16:0]  w_sum;
  logic [15:0]         w_sat;

  // Sensor order: inner right/left, middle right/left, outer right/left.
  function automatic logic [2:0] chnl_of(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'd1;
      3'd1:    return 3'd0;
      3'd2:    return 3'd4;
      3'd3:    return 3'd2;
      3'd4:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  assign w_settle_done = (r_cnt == CW'(SETTLE_CYC - 1));
  assign w_last        = (r_idx == 3'd5);
  assign w_idx_nxt     = r_idx + 3'd1;

  always_comb begin
    w_mag = '0;
    case (r_idx[2:1])
      2'b00:   w_mag = $signed({5'b0, A2D_res});
      2'b01:   w_mag = $signed({4'b0, A2D_res, 1'b0});
      default: w_mag = $signed({2'b0, A2D_res, 3'b0});
    endcase
    w_sum = r_idx[0] ? (r_acc - w_mag) : (r_acc + w_mag);
    if (w_sum > 17'sd32767)
      w_sat = 16'h7FFF;
    else if (w_sum < -17'sd32768)
      w_sat = 16'h8000;
    else
      w_sat = w_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_strt = 1'b0;
    case (r_state)
      IDLE:    if (go) w_next = SETTLE;
      SETTLE:  if (w_settle_done) w_next = START;
      START: begin
        w_strt = 1'b1;
        w_next = WAIT;
      end
      WAIT:    if (cnv_cmplt) w_next = w_last ? IDLE : START;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_chnl    <= '0;
      r_acc     <= '0;
      r_error   <= '0;
      r_err_vld <= 1'b0;
      r_ir_en   <= 1'b0;
    end else begin
      r_err_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          r_acc <= '0;
          r_idx <= '0;
          r_cnt <= '0;
          if (go) r_ir_en <= 1'b1;
        end
        SETTLE: begin
          if (w_settle_done)
            r_chnl <= chnl_of(r_idx);
          else
            r_cnt <= r_cnt + CW'(1);
        end
        WAIT: begin
          if (cnv_cmplt) begin
            r_acc <= w_sum;
            if (w_last) begin
              r_error   <= w_sat;
              r_err_vld <= 1'b1;
              r_ir_en   <= 1'b0;
            end else begin
              r_idx  <= w_idx_nxt;
              r_chnl <= chnl_of(w_idx_nxt);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign strt_cnv = w_strt;
  assign chnl     = r_chnl;
  assign IR_en    = r_ir_en;
  assign busy     = (r_state != IDLE);
  assign error    = r_error;
  assign err_vld  = r_err_vld;

endmodule

// File: tb/tb_ir_line_seq.sv
// Directed and randomized sweeps of ir_line_seq against a sum-of-weighted-readings
// reference, with a 3-cycle-latency A2D responder.
module tb_ir_line_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        cc;
  logic [11:0] res;
  logic        strt_cnv;
  logic [2:0]  chnl;
  logic        IR_en;
  logic        busy;
  logic [15:0] error;
  logic        err_vld;

  int checks = 0;
  int errors = 0;
  int vals[8];
  int tbl[6] = '{1, 0, 4, 2, 3, 7};
  logic [15:0] exp_prev = '0;

  ir_line_seq #(.SETTLE_CYC(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .cnv_cmplt(cc),
    .A2D_res  (res),
    .strt_cnv (strt_cnv),
    .chnl     (chnl),
    .IR_en    (IR_en),
    .busy     (busy),
    .error    (error),
    .err_vld  (err_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: right sensors add, left subtract, pair weights 1/2/8, clamp to 16 bits.
  function automatic logic [15:0] model_err();
    int s = 0;
    for (int i = 0; i < 6; i++) begin
      int w = (i < 2) ? 1 : (i < 4) ? 2 : 8;
      int t = vals[tbl[i]] * w;
      s += (i % 2 == 0) ? t : -t;
    end
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic set_vals(input int r, input int l);
    for (int c = 0; c < 8; c++) vals[c] = 0;
    vals[1] = r; vals[4] = r; vals[3] = r;
    vals[0] = l; vals[2] = l; vals[7] = l;
  endtask

  task automatic rand_vals();
    for (int c = 0; c < 8; c++) vals[c] = int'($urandom_range(0, 4095));
  endtask

  // go_mode: 0 drop go at once, 1 drop after second strt_cnv, 2 hold go (next sweep follows).
  task automatic sweep(input int go_mode, input bit spur, input bit do_rst);
    int off = 0, nstrt = 0, last_s = 0, due = 0;
    bit pend = 0, stale = 0, done = 0;
    logic [2:0] pch = '0;
    logic [15:0] exp_e;
    exp_e = model_err();
    go = 1'b1;
    while (!done) begin
      @(posedge clk); #1; off++;
      if (off == 1) begin
        chk("busy_rise", busy, 1);
        chk("ir_rise", IR_en, 1);
        chk("err_hold", error, exp_prev);
        if (go_mode == 0) go = 1'b0;
      end
      if (pend && !stale) chk("chnl_stable", chnl, pch);
      if (strt_cnv) begin
        if (nstrt == 0) chk("settle_len", off, 9);
        if (nstrt < 6) chk("chnl_seq", chnl, 32'(tbl[nstrt]));
        chk("ir_on", IR_en, 1);
        nstrt++;
        last_s = off;
        if (go_mode == 1 && nstrt == 2) go = 1'b0;
      end
      if (err_vld) begin
        chk("vld_time", off, last_s + 4);
        chk("n_strt", nstrt, 6);
        chk("error", error, exp_e);
        chk("busy_off", busy, 0);
        chk("ir_off", IR_en, 0);
        exp_prev = exp_e;
        done = 1;
      end
      if (pend && off == due) begin
        cc = 1'b1;
        res = stale ? 12'($urandom) : 12'(vals[pch]);
        pend = 0;
      end else if (spur && (off == 3 || off == 8 || strt_cnv)) begin
        cc = 1'b1;
        res = 12'($urandom);
      end else begin
        cc = 1'b0;
        res = 12'($urandom);
      end
      if (strt_cnv) begin
        pend = 1; stale = 0; due = off + 3; pch = chnl;
      end
      if (do_rst && nstrt == 4 && off == last_s + 1) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_strt", strt_cnv, 0);
        chk("rst_chnl", chnl, 0);
        chk("rst_ir", IR_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vld", err_vld, 0);
        chk("rst_err", error, 0);
        #1 rst = 1'b0;
        exp_prev = '0;
        due = due - off;
        stale = 1; off = 0; nstrt = 0; last_s = 0; do_rst = 0;
        go = 1'b1;
      end
      if (!done && off >= 120) begin
        checks++;
        errors++;
        $error("FAIL timeout observed_off=%0d expected_err_vld_by=%0d", off, 120);
        done = 1;
      end
    end
    if (go_mode != 2) begin
      go = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_vld", err_vld, 0);
        chk("idle_err", error, exp_prev);
      end
    end
  endtask

  initial begin
    rst = 1'b0; go = 1'b0; cc = 1'b0; res = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_strt", strt_cnv, 0);
    chk("reset_chnl", chnl, 0);
    chk("reset_ir", IR_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_vld", err_vld, 0);
    chk("reset_err", error, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_go", busy, 0);

    set_vals(100, 0);    sweep(2, 0, 0);
    set_vals(0, 100);    sweep(0, 0, 0);
    set_vals(4095, 0);   sweep(0, 0, 0);
    set_vals(0, 4095);   sweep(0, 0, 0);
    set_vals(2000, 2000); sweep(0, 0, 0);
    for (int n = 0; n < 6; n++) begin
      rand_vals();
      sweep(0, 0, 0);
    end
    rand_vals();         sweep(1, 0, 0);
    set_vals(100, 0);    sweep(0, 1, 0);
    rand_vals();         sweep(0, 0, 1);
    rand_vals();         sweep(0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ir_line_seq.md
# ir_line_seq

Sequences the shared A2D converter across the six IR line sensors of the follower and reduces the readings to one signed steering error per sweep. It sits between the command controller, whose `go` enables sweeping, and the A2D SPI interface (`strt_cnv`/`chnl`/`cnv_cmplt`/`A2D_res`). Its `error`/`err_vld` feed the PI motor controller. It also owns the IR emitter enable, asserting it only while a sweep is in progress.

## Interface
- `SETTLE_CYC`, default 4096: cycles the IR emitters settle before the first conversion of a sweep (≥1).
- `clk` in 1: single system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `go` in 1: sweep enable from the command controller.
- `cnv_cmplt` in 1: A2D conversion done; `A2D_res` is valid while it is high.
- `A2D_res` in 12: unsigned conversion result.
- `strt_cnv` out 1: one-cycle conversion start pulse.
- `chnl` out 3: A2D channel select, stable from `strt_cnv` until the matching `cnv_cmplt`.
- `IR_en` out 1: IR emitter enable.
- `busy` out 1: high whenever the state is not IDLE.
- `error` out 16: signed, saturated steering error, held between sweeps.
- `err_vld` out 1: one-cycle pulse when `error` updates.

## Operation
- Reset values: state IDLE; `strt_cnv`, `IR_en`, `busy`, `err_vld` = 0; `chnl` = 0; `error` = 0; accumulator = 0; index = 0; settle counter = 0.
- States:
  - IDLE: leaves to SETTLE when `go`=1; clears accumulator, index and counter; sets `IR_en`.
  - SETTLE: counts `SETTLE_CYC` cycles, then goes to START.
  - START: `strt_cnv`=1 for this cycle only, `chnl` = table[index]; then goes to WAIT.
  - WAIT: waits for `cnv_cmplt`; on it, accumulates and either goes to START (index<5) or to IDLE (index=5).
- Channel table, index 0..5: 1, 0, 4, 2, 3, 7.
- Sign and weight per index:
  - Even index is a right sensor and is added; odd index is a left sensor and is subtracted.
  - Pair p = index/2 has weight shift 0, 1, 3 (×1, ×2, ×8) for inner, middle, outer.
- Arithmetic: the term is {0,A2D_res} << shift, applied to a 17-bit signed accumulator. The maximum magnitude is 4095·11 = 45045, so the accumulator never wraps.
- Final step (index 5):
  - `error` ← sat16(acc ± term), clamped to [−32768, 32767].
  - `err_vld` ← 1 for one cycle; `IR_en` ← 0.
  - State → IDLE.
- `go` is sampled only in IDLE. Dropping `go` mid-sweep does not abort: the sweep completes and `err_vld` fires. With `go` held, a new sweep starts from IDLE on the next edge, including a fresh settle.
- `cnv_cmplt` is ignored outside WAIT, including during SETTLE and in the START cycle itself.
- Reset mid-sweep: all outputs return to reset values immediately, without waiting for a clock edge, and the partial sweep is discarded. A conversion left in flight in the A2D is ignored, per the previous rule.

## Timing
- `go`=1 in IDLE at edge N: `IR_en`=`busy`=1 from cycle N+1.
- First `strt_cnv` is in cycle N+1+`SETTLE_CYC`.
- `cnv_cmplt` high in cycle M (in WAIT): the result is captured at the end of cycle M. The next `strt_cnv` is in cycle M+1; there is no idle gap between conversions.
- Sixth `cnv_cmplt` in cycle M: `err_vld`=1 and the new `error` are in cycle M+1, with `IR_en`=0 and `busy`=0 in the same cycle.
- `error` holds its value until the next `err_vld`.
- Minimum sweep length with a k-cycle A2D latency: 1 + `SETTLE_CYC` + 6·(k+1) cycles.

## Test plan
- Bench conditions: `SETTLE_CYC`=8; A2D model asserts `cnv_cmplt` 3 cycles after `strt_cnv`.
- Order and pulse check, `go` held one sweep: exactly 6 single-cycle `strt_cnv` pulses with `chnl` = 1, 0, 4, 2, 3, 7. `IR_en` rises 9 cycles before the first pulse and falls with `err_vld`.
- Right channels (1, 4, 3) return 100, left return 0 → `error` = 1100, `err_vld` high for exactly 1 cycle. Swap the values → `error` = −1100.
- Saturation: all right = 4095, left = 0 → `error` = 32767. All left = 4095, right = 0 → −32768. Equal readings of 2000 → 0.
- `go` dropped after the second `strt_cnv`: the sweep still produces 6 conversions and `err_vld`, then stays IDLE with `busy`=0. With `go` held, a second sweep begins the cycle after `err_vld`.
- Spurious `cnv_cmplt` during SETTLE and in the START cycle → no accumulation, no index advance, and the result is unchanged from the clean run.
- `rst` pulsed asynchronously mid-WAIT at sweep index 3 → outputs zero before the next edge. After release with `go`=1, a fresh sweep restarts at `chnl`=1 with a full settle.
